// File: rtl/mxu_pkg.sv
// Shared types and sizing helpers for the systolic matrix unit.
// Imported by the top level and the PE.
package mxu_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

  function automatic int kw_of(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int rw_of(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // The flush counter runs 0 .. rows+cols-2.
  function automatic int fw_of(input int rows, input int cols);
    return (rows + cols > 2) ? $clog2(rows + cols - 1) : 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// Output-stationary signed MAC processing element.
// Forwards operands east/south through one register and accumulates their product.
module mac_pe
  import mxu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] west_in,
  input  logic signed [DATA_W-1:0] north_in,
  output logic signed [DATA_W-1:0] east_out,
  output logic signed [DATA_W-1:0] south_out,
  output logic signed [ACC_W-1:0]  acc
);

  // Full-precision product, sign-extended; accumulation wraps modulo 2^ACC_W.
  function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return ACC_W'(prod);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      east_out  <= '0;
      south_out <= '0;
      acc       <= '0;
    end else if (ce) begin
      if (clr) begin
        east_out  <= '0;
        south_out <= '0;
        acc       <= '0;
      end else begin
        east_out  <= west_in;
        south_out <= north_in;
        acc       <= acc + mul_ext(west_in, north_in);
      end
    end
  end

endmodule

// File: rtl/systolic_mxu.sv
// ROWS x COLS output-stationary systolic matrix unit with input skew,
// valid/ready streaming, run-control FSM with flush and row-serial drain.
module systolic_mxu
  import mxu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 256,
  localparam int KW    = kw_of(K_MAX),
  localparam int RW    = rw_of(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] west_data,
  input  logic [COLS*DATA_W-1:0] north_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   done
);

  localparam int FW = fw_of(ROWS, COLS);

  state_t              state;
  logic [KW-1:0]       k_len_q;
  logic [KW-1:0]       k_cnt;
  logic [FW-1:0]       fl_cnt;
  logic                fire;
  logic                clr;
  logic [RW-1:0]       row_sel;
  logic [COLS*ACC_W-1:0] row_data;
  logic                unused_edge;

  logic signed [DATA_W-1:0] west_inj  [ROWS];
  logic signed [DATA_W-1:0] north_inj [COLS];
  logic signed [DATA_W-1:0] h_bus     [ROWS][COLS+1];
  logic signed [DATA_W-1:0] v_bus     [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc_grid  [ROWS][COLS];

  assign busy     = (state != IDLE);
  assign in_ready = ce && (state == STREAM);
  assign fire     = in_ready && in_valid;
  assign clr      = ce && (state == IDLE) && start;

  // Cycles without a handshake feed zeros so they add nothing to the sums.
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      west_inj[i] = fire ? west_data[lane_lsb(i, DATA_W) +: DATA_W] : '0;
    for (int j = 0; j < COLS; j++)
      north_inj[j] = fire ? north_data[lane_lsb(j, DATA_W) +: DATA_W] : '0;
  end

  // ---- stage boundary: west skew, lane i delayed by i registers ----
  for (genvar i = 0; i < ROWS; i++) begin : g_wskew
    if (i == 0) begin : g_direct
      assign h_bus[0][0] = west_inj[0];
    end else begin : g_delay
      logic signed [DATA_W-1:0] dly_p [i];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) dly_p[s] <= '0;
        end else if (ce) begin
          dly_p[0] <= clr ? '0 : west_inj[i];
          for (int s = 1; s < i; s++) dly_p[s] <= clr ? '0 : dly_p[s-1];
        end
      end
      assign h_bus[i][0] = dly_p[i-1];
    end
  end

  // ---- stage boundary: north skew, lane j delayed by j registers ----
  for (genvar j = 0; j < COLS; j++) begin : g_nskew
    if (j == 0) begin : g_direct
      assign v_bus[0][0] = north_inj[0];
    end else begin : g_delay
      logic signed [DATA_W-1:0] dly_p [j];
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int s = 0; s < j; s++) dly_p[s] <= '0;
        end else if (ce) begin
          dly_p[0] <= clr ? '0 : north_inj[j];
          for (int s = 1; s < j; s++) dly_p[s] <= clr ? '0 : dly_p[s-1];
        end
      end
      assign v_bus[0][j] = dly_p[j-1];
    end
  end

  // ---- stage boundary: PE grid ----
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .clr      (clr),
        .west_in  (h_bus[i][j]),
        .north_in (v_bus[i][j]),
        .east_out (h_bus[i][j+1]),
        .south_out(v_bus[i+1][j]),
        .acc      (acc_grid[i][j])
      );
    end
  end

  // The east and south edges of the grid have no consumer.
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < ROWS; i++) unused_edge = unused_edge ^ (^h_bus[i][COLS]);
    for (int j = 0; j < COLS; j++) unused_edge = unused_edge ^ (^v_bus[ROWS][j]);
  end

  // Row to load into out_data at the next transition: row 0 on entry, else the next row.
  always_comb begin
    row_sel = '0;
    if (state == DRAIN && out_row != RW'(ROWS-1)) row_sel = out_row + RW'(1);
    row_data = '0;
    for (int j = 0; j < COLS; j++)
      row_data[lane_lsb(j, ACC_W) +: ACC_W] = acc_grid[row_sel][j];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      k_len_q   <= '0;
      k_cnt     <= '0;
      fl_cnt    <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ce) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              k_len_q <= k_len;
              k_cnt   <= '0;
              fl_cnt  <= '0;
              out_row <= '0;
              if (k_len == '0) begin
                state     <= DRAIN;
                out_valid <= 1'b1;
                out_data  <= '0;
              end else begin
                state <= STREAM;
              end
            end
          end
          STREAM: begin
            if (in_valid) begin
              k_cnt <= k_cnt + KW'(1);
              if (k_cnt == k_len_q - KW'(1)) state <= FLUSH;
            end
          end
          FLUSH: begin
            fl_cnt <= fl_cnt + FW'(1);
            if (fl_cnt == FW'(ROWS+COLS-2)) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_row   <= '0;
              out_data  <= row_data;
            end
          end
          DRAIN: begin
            if (out_ready) begin
              if (out_row == RW'(ROWS-1)) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_row   <= '0;
                done      <= 1'b1;
              end else begin
                out_row  <= out_row + RW'(1);
                out_data <= row_data;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_mxu.sv
// Scoreboard bench for systolic_mxu: driver pushes expected rows, a monitor
// pops and compares on every presented row.
module tb_systolic_mxu;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int K_MAX  = 256;
  localparam int KW     = $clog2(K_MAX + 1);
  localparam int RW     = 2;
  localparam int OW     = COLS * ACC_W;

  typedef struct {
    int            row;
    logic [OW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [KW-1:0] k_len = '0;
  logic [ROWS*DATA_W-1:0] west_data = '0;
  logic [COLS*DATA_W-1:0] north_data = '0;
  logic busy, in_ready, out_valid, done;
  logic [RW-1:0] out_row;
  logic [OW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rdy_cnt = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  bit stall_en = 1'b0;
  bit hold_ready = 1'b0;
  exp_t exp_q[$];
  int A [ROWS][K_MAX];
  int B [K_MAX][COLS];

  systolic_mxu #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .west_data(west_data),
    .north_data(north_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #2;
    out_ready = hold_ready ? 1'b0 : (stall_en ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented row is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_row", OW'(out_valid), OW'(0));
      end else begin
        chk("row_idx", OW'(out_row), OW'(exp_q[0].row));
        chk("row_data", out_data, exp_q[0].data);
        if (out_ready && ce) void'(exp_q.pop_front());
      end
    end
    if (done) done_cnt++;
    if (in_ready) rdy_cnt++;
  end

  task automatic push_row(input int r, input int c0, input int c1, input int c2, input int c3);
    exp_t e;
    e.row  = r;
    e.data = {ACC_W'(c3), ACC_W'(c2), ACC_W'(c1), ACC_W'(c0)};
    exp_q.push_back(e);
  endtask

  // Reference: C[i][j] = sum_t A[i][t]*B[t][j], reduced modulo 2^ACC_W.
  task automatic push_model(input int k);
    for (int i = 0; i < ROWS; i++) begin
      exp_t e;
      longint s;
      e.row  = i;
      e.data = '0;
      for (int j = 0; j < COLS; j++) begin
        s = 0;
        for (int t = 0; t < k; t++) s += longint'(A[i][t]) * longint'(B[t][j]);
        e.data[j*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_ab();
    for (int t = 0; t < K_MAX; t++) begin
      for (int i = 0; i < ROWS; i++) A[i][t] = 0;
      for (int j = 0; j < COLS; j++) B[t][j] = 0;
    end
  endtask

  task automatic fill_rand(input int k);
    clear_ab();
    for (int t = 0; t < k; t++) begin
      for (int i = 0; i < ROWS; i++) A[i][t] = int'($urandom_range(0, 65535)) - 32768;
      for (int j = 0; j < COLS; j++) B[t][j] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic drive_beat(input int b);
    for (int i = 0; i < ROWS; i++) west_data[i*DATA_W +: DATA_W] = DATA_W'(A[i][b]);
    for (int j = 0; j < COLS; j++) north_data[j*DATA_W +: DATA_W] = DATA_W'(B[b][j]);
    in_valid = 1'b1;
  endtask

  task automatic drive_junk();
    for (int i = 0; i < ROWS; i++) west_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    for (int j = 0; j < COLS; j++) north_data[j*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, OW'(busy), OW'(0));
    chk({tag, "_in_ready"}, OW'(in_ready), OW'(0));
    chk({tag, "_out_valid"}, OW'(out_valid), OW'(0));
    chk({tag, "_done"}, OW'(done), OW'(0));
    chk({tag, "_out_row"}, OW'(out_row), OW'(0));
    chk({tag, "_out_data"}, out_data, OW'(0));
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done_once"}, OW'(done_cnt), OW'(d0 + 1));
    chk({tag, "_queue_empty"}, OW'(exp_q.size()), OW'(0));
  endtask

  task automatic run_job(input int k, input bit gaps, input bit stalls, input bit ce_gap,
                         input bit abort, input int exp_lat);
    int n, d0;
    bit hs;
    d0 = done_cnt;
    stall_en = stalls;
    first_valid_cyc = -1;
    k_len = KW'(k);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int b = 0; b < k; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          drive_junk();
          @(posedge clk);
          #1;
        end
      end
      drive_beat(b);
      if (ce_gap && b == 2) begin
        ce = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("ce_low_in_ready", OW'(in_ready), OW'(0));
          chk("ce_low_busy", OW'(busy), OW'(1));
          @(posedge clk);
          #1;
        end
        ce = 1'b1;
      end
      n = 0;
      hs = 1'b0;
      while (!hs && n < 100) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      chk("beat_accept", OW'(hs), OW'(1));
    end
    in_valid = 1'b0;
    if (abort) begin
      repeat (2) @(posedge clk);
      #1;
      chk("abort_busy_in_flush", OW'(busy), OW'(1));
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check_idle("abort");
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_done", OW'(done_cnt), OW'(d0));
      chk("abort_stays_idle", OW'(busy), OW'(0));
      stall_en = 1'b0;
      return;
    end
    wait_done(d0, "job");
    if (exp_lat > 0) chk("latency", OW'(first_valid_cyc - start_cyc), OW'(exp_lat));
    repeat (3) @(posedge clk);
    #1;
    chk("done_single", OW'(done_cnt), OW'(d0 + 1));
    chk("idle_after_job", OW'(busy), OW'(0));
    stall_en = 1'b0;
  endtask

  task automatic load_2x2();
    clear_ab();
    A[0][0] = 1; A[1][0] = 3; A[0][1] = 2; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
    push_row(0, 19, 22, 0, 0);
    push_row(1, 43, 50, 0, 0);
    push_row(2, 0, 0, 0, 0);
    push_row(3, 0, 0, 0, 0);
  endtask

  initial begin
    int d0, r0, kr;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    load_2x2();
    run_job(2, 0, 0, 0, 0, 1 + 2 + 7);

    fill_rand(4);
    for (int t = 0; t < 4; t++)
      for (int j = 0; j < COLS; j++) B[t][j] = (t == j) ? 1 : 0;
    for (int i = 0; i < ROWS; i++) push_row(i, A[i][0], A[i][1], A[i][2], A[i][3]);
    run_job(4, 0, 0, 0, 0, 12);

    clear_ab();
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < ROWS; i++) A[i][t] = -32768;
      for (int j = 0; j < COLS; j++) B[t][j] = -32768;
    end
    for (int i = 0; i < ROWS; i++)
      push_row(i, int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000));
    run_job(2, 0, 0, 0, 0, 0);

    clear_ab();
    for (int i = 0; i < ROWS; i++) A[i][0] = -1;
    for (int j = 0; j < COLS; j++) B[0][j] = 5;
    for (int i = 0; i < ROWS; i++) push_row(i, -5, -5, -5, -5);
    run_job(1, 0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      kr = $urandom_range(1, 12);
      fill_rand(kr);
      push_model(kr);
      run_job(kr, 1, 1, 0, 0, 0);
    end

    fill_rand(K_MAX);
    push_model(K_MAX);
    run_job(K_MAX, 0, 0, 0, 0, 1 + K_MAX + 7);

    // k_len = 0: straight to DRAIN; start and in_valid during DRAIN are ignored.
    for (int i = 0; i < ROWS; i++) push_row(i, 0, 0, 0, 0);
    d0 = done_cnt;
    r0 = rdy_cnt;
    hold_ready = 1'b1;
    k_len = '0;
    start = 1'b1;
    drive_junk();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    k_len = KW'(3);
    repeat (2) begin
      @(negedge clk);
      chk("k0_drain_busy", OW'(busy), OW'(1));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold_ready = 1'b0;
    wait_done(d0, "k0");
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("k0_no_in_ready", OW'(rdy_cnt), OW'(r0));
    chk("k0_start_ignored", OW'(busy), OW'(0));

    fill_rand(6);
    push_model(6);
    run_job(6, 0, 0, 1, 0, 1 + 6 + 7 + 5);

    fill_rand(4);
    run_job(4, 0, 0, 1, 1, 0);

    load_2x2();
    run_job(2, 0, 0, 0, 0, 1 + 2 + 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog: run exceeded time limit, got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_mxu.md
Name: systolic_mxu

Overview:
Parametrised output-stationary systolic matrix unit: a ROWS x COLS grid of signed MAC PEs computing C = A x B over a runtime inner dimension k_len. It is the successor to the fixed 2x2, 16-bit MAC grid. New in this generation: internal input skew, a valid/ready streaming interface, a run-control FSM with flush, and a row-serial result drain. It sits between the operand buffers (A rows west, B columns north) and the result writeback path.

Parameters:
DATA_W, 16, operand width (signed two's complement)
ACC_W, 32, accumulator/result width; must be >= 2*DATA_W
ROWS, 4, PE rows (A rows / C rows), >= 1
COLS, 4, PE columns (B columns / C columns), >= 1
K_MAX, 256, maximum inner dimension; KW = $clog2(K_MAX+1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (asserted when 0)
ce  in  1  global clock enable; low freezes all state
start  in  1  begin a job; sampled only in IDLE
k_len  in  KW  inner dimension, latched on start; 0..K_MAX
busy  out  1  high in any state other than IDLE
in_valid  in  1  west/north beat valid
in_ready  out  1  high when ce=1 and state==STREAM
west_data  in  ROWS*DATA_W  lane i = A[i][k]
north_data  in  COLS*DATA_W  lane j = B[k][j]
out_valid  out  1  result row valid
out_ready  in  1  consumer accepts the row
out_row  out  $clog2(ROWS) (min 1)  index of the row presented
out_data  out  COLS*ACC_W  lane j = C[out_row][j]
done  out  1  one-cycle pulse on the final row handshake

Behaviour:
- Reset (rst=0 at a clock edge): FSM=IDLE, all PE accumulators, skew and pass registers cleared. busy, in_ready, out_valid, done = 0; out_row = 0; out_data = 0. Reset overrides ce and aborts any job mid-operation; no partial output follows.
- ce=0: FSM, counters, skew/pass registers and accumulators hold. Outputs hold their values, except in_ready, which is forced to 0. done never asserts while ce=0.
- IDLE: start=1 latches k_len and clears all accumulators and pass registers. Next state is STREAM if k_len>0, else DRAIN (result all zeros).
- STREAM: each beat with in_valid & in_ready is a handshake. West lane i enters through an i-stage skew delay; north lane j enters through a j-stage delay. A cycle without a handshake injects zeros (a bubble), which does not affect results. After k_len handshakes, go to FLUSH.
- FLUSH: inject zeros for exactly ROWS+COLS-1 cycles, so that PE(ROWS-1,COLS-1) has absorbed its last product. Then go to DRAIN with out_row=0.
- DRAIN: out_valid=1 and out_data = accumulators of row out_row. On out_valid & out_ready, out_row increments. After row ROWS-1 is accepted, done pulses and the FSM returns to IDLE. Under backpressure, out_data and out_row stay stable until the handshake.
- PE: acc <= acc + sext(west*north). The product is a full 2*DATA_W signed value, sign-extended to ACC_W; the sum wraps modulo 2^ACC_W. The PE passes west data east and north data south with one register stage.
- Latency: with continuous in_valid, out_ready and ce, the first out_valid occurs 1 + k_len + (ROWS+COLS-1) cycles after the start cycle.
- start outside IDLE is ignored. in_valid outside STREAM is ignored. Beats beyond k_len are never accepted.

Decomposition:
- Package mxu_pkg holds the FSM state enum (IDLE, STREAM, FLUSH, DRAIN) and localparam helpers for lane slicing and KW.
- Sub-module mac_pe: one PE with clk, rst, ce, clr, west_in, north_in, east_out, south_out, acc. Instantiated ROWS x COLS times in a generate grid.
- Skew delay lines and the FSM live in the top-level module.

Test Plan:
- 2x2 multiply, DATA_W=16: k_len=2. Beat0 west=(1,3), north=(5,6); beat1 west=(2,4), north=(7,8) -> row0=(19,22), row1=(43,50), then done.
- 4x4 with identity B, random A, k_len=4, continuous streaming: rows equal A. First out_valid exactly 1+4+7=12 cycles after start.
- Signed and wrap: ACC_W=32, k_len=2, a=-32768 and b=-32768 on both beats -> 0x80000000 (wraps). A=-1, B=5 -> -5.
- Bubbles and backpressure: random in_valid gaps during STREAM and random out_ready stalls in DRAIN -> same results as without gaps. out_data stays stable while stalled. done fires exactly once.
- k_len=0 -> STREAM and FLUSH skipped, ROWS zero rows drained, in_ready never asserted. start during DRAIN -> ignored.
- ce low for 5 cycles mid-STREAM, then rst=0 mid-FLUSH -> state frozen during ce low; after reset, IDLE with outputs 0. A following 2x2 job gives correct results.
